// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
// Shared types, field limits and BCD helper functions for the RTC/calendar
// core. All arithmetic stays in packed BCD; nothing is converted to binary.
// ---------------------------------------------------------------------------
package rtc_pkg;

    // Edit FSM; the encoding is exported on edit_field and drives LEDs.
    typedef enum logic [2:0] {
        RUN    = 3'd0,
        E_SEC  = 3'd1,
        E_MIN  = 3'd2,
        E_HOUR = 3'd3,
        E_DAY  = 3'd4,
        E_MON  = 3'd5,
        E_YEAR = 3'd6,
        E_WDAY = 3'd7
    } edit_state_e;

    typedef logic [7:0]  bcd2_t;
    typedef logic [15:0] bcd4_t;

    localparam bcd2_t SEC_MAX   = 8'h59;
    localparam bcd2_t MIN_MAX   = 8'h59;
    localparam bcd2_t HOUR_MAX  = 8'h23;
    localparam bcd2_t DAY_MIN   = 8'h01;
    localparam bcd2_t MONTH_MIN = 8'h01;
    localparam bcd2_t MONTH_MAX = 8'h12;
    localparam logic [2:0] WDAY_MAX = 3'd6;

    // Two-digit BCD value divisible by 4: (10t + o) mod 4 == (2t + o) mod 4,
    // so only the parity of the tens digit and the ones digit matter.
    function automatic logic bcd_div4(input bcd2_t v);
        logic [3:0] o;
        o = v[3:0];
        if (v[4] == 1'b0) return (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
        else              return (o == 4'd2) || (o == 4'd6);
    endfunction

    // Gregorian rule: a century year (low pair 00) is leap when the century
    // pair is divisible by 4 (i.e. year divisible by 400).
    function automatic logic is_leap_bcd(input bcd4_t y);
        if (y[7:0] == 8'h00) return bcd_div4(y[15:8]);
        else                 return bcd_div4(y[7:0]);
    endfunction

    function automatic bcd2_t days_in_month_bcd(input bcd2_t mo, input bcd4_t y);
        case (mo)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return is_leap_bcd(y) ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic bcd2_t bcd2_inc(input bcd2_t v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return v + 8'd1;
    endfunction

    function automatic bcd2_t bcd2_dec(input bcd2_t v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                return v - 8'd1;
    endfunction

    // Wrap-around step within [lo, hi], no carry out.
    function automatic bcd2_t bcd2_step(input bcd2_t v, input bcd2_t lo,
                                        input bcd2_t hi, input logic up);
        if (up) return (v == hi) ? lo : bcd2_inc(v);
        else    return (v == lo) ? hi : bcd2_dec(v);
    endfunction

    // Four-digit year step, 9999 <-> 0000 wrap.
    function automatic bcd4_t bcd4_step(input bcd4_t v, input logic up);
        bcd2_t lo;
        bcd2_t hi;
        lo = v[7:0];
        hi = v[15:8];
        if (up) begin
            if (lo == 8'h99) begin
                lo = 8'h00;
                hi = (hi == 8'h99) ? 8'h00 : bcd2_inc(hi);
            end else begin
                lo = bcd2_inc(lo);
            end
        end else begin
            if (lo == 8'h00) begin
                lo = 8'h99;
                hi = (hi == 8'h00) ? 8'h99 : bcd2_dec(hi);
            end else begin
                lo = bcd2_dec(lo);
            end
        end
        return {hi, lo};
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// ---------------------------------------------------------------------------
// rtc_prescaler
// Counts clk cycles 0..DIV-1 with DIV = fast ? FAST_DIV : TICK_DIV and
// asserts tick (combinational from the count) during the cycle whose count
// has reached DIV-1; the count clears on that edge. hold forces the count
// to 0 and suppresses tick.
//   clk, rst_n : clock, async active-low reset
//   hold       : keep counter cleared, no ticks
//   fast       : select FAST_DIV divisor
//   tick       : high for the cycle in which the count reaches DIV-1
// ---------------------------------------------------------------------------
module rtc_prescaler #(
    parameter int TICK_DIV = 50_000_000,
    parameter int FAST_DIV = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic fast,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] last;

    assign last = fast ? FAST_LAST : TICK_LAST;
    // >= rather than == so a switch to a shorter divisor mid-count fires
    // on the next edge instead of running past the terminal value.
    assign tick = !hold && (count >= last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            count <= '0;
        else if (hold || tick) count <= '0;
        else                   count <= count + CW'(1);
    end

endmodule

// File: rtl/rtc_calendar_core.sv
// ---------------------------------------------------------------------------
// rtc_calendar_core
// BCD real-time clock and Gregorian calendar with in-place field editing.
// Optional macro RTC_WEEKDAY_EN adds the weekday register, port and the
// E_WDAY edit state.
//   clk, rst_n      : clock, async active-low reset
//   fast            : use FAST_DIV prescale
//   edit_next/inc/dec : single-cycle strobes, sampled every rising edge with
//                     no back-pressure; edit_next wins over inc/dec, and
//                     inc together with dec is ignored
//   time_bcd        : {hh, mm, ss}
//   date_bcd        : {dd, mo, yyyy}
//   edit_field      : FSM state (RUN=0 .. E_YEAR=6, E_WDAY=7)
//   sec_pulse       : one cycle per seconds tick in RUN
//   day_pulse       : one cycle on 23:59:59 -> 00:00:00
//   weekday         : 0=Sun..6=Sat (RTC_WEEKDAY_EN only)
// ---------------------------------------------------------------------------
module rtc_calendar_core
    import rtc_pkg::*;
#(
    parameter int          TICK_DIV   = 50_000_000,
    parameter int          FAST_DIV   = 500,
    parameter logic [15:0] YEAR_RESET = 16'h2024,
    parameter logic [2:0]  WDAY_RESET = 3'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fast,
    input  logic        edit_next,
    input  logic        inc,
    input  logic        dec,
    output logic [23:0] time_bcd,
    output logic [31:0] date_bcd,
    output logic [2:0]  edit_field,
    output logic        sec_pulse,
    output logic        day_pulse
`ifdef RTC_WEEKDAY_EN
    ,
    output logic [2:0]  weekday
`endif
);

    edit_state_e state_q, state_d;
    bcd2_t ss_q, mm_q, hh_q, dd_q, mo_q;
    bcd2_t ss_d, mm_d, hh_d, dd_d, mo_d;
    bcd4_t yy_q, yy_d;
    bcd2_t new_max;
    logic  sec_pulse_d, day_pulse_d;
    logic  tick, hold, step_en, step_up;

    rtc_prescaler #(
        .TICK_DIV (TICK_DIV),
        .FAST_DIV (FAST_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold),
        .fast  (fast),
        .tick  (tick)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (edit_next) begin
            case (state_q)
                RUN:     state_d = E_SEC;
                E_SEC:   state_d = E_MIN;
                E_MIN:   state_d = E_HOUR;
                E_HOUR:  state_d = E_DAY;
                E_DAY:   state_d = E_MON;
                E_MON:   state_d = E_YEAR;
`ifdef RTC_WEEKDAY_EN
                E_YEAR:  state_d = E_WDAY;
`else
                E_YEAR:  state_d = RUN;
`endif
                default: state_d = RUN;
            endcase
        end
    end

    // FSM: control outputs
    always_comb begin
        hold    = (state_q != RUN);
        step_en = (state_q != RUN) && !edit_next && (inc ^ dec);
        step_up = inc;
    end

    // Time/date datapath: tick cascade in RUN, field edits otherwise, then
    // a day clamp so a month/year change never leaves dd past month end.
    always_comb begin
        ss_d        = ss_q;
        mm_d        = mm_q;
        hh_d        = hh_q;
        dd_d        = dd_q;
        mo_d        = mo_q;
        yy_d        = yy_q;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        new_max     = 8'h31;
        if (tick) begin
            sec_pulse_d = 1'b1;
            if (ss_q != SEC_MAX) begin
                ss_d = bcd2_inc(ss_q);
            end else begin
                ss_d = 8'h00;
                if (mm_q != MIN_MAX) begin
                    mm_d = bcd2_inc(mm_q);
                end else begin
                    mm_d = 8'h00;
                    if (hh_q != HOUR_MAX) begin
                        hh_d = bcd2_inc(hh_q);
                    end else begin
                        hh_d        = 8'h00;
                        day_pulse_d = 1'b1;
                        if (dd_q != days_in_month_bcd(mo_q, yy_q)) begin
                            dd_d = bcd2_inc(dd_q);
                        end else begin
                            dd_d = DAY_MIN;
                            if (mo_q != MONTH_MAX) begin
                                mo_d = bcd2_inc(mo_q);
                            end else begin
                                mo_d = MONTH_MIN;
                                yy_d = bcd4_step(yy_q, 1'b1);
                            end
                        end
                    end
                end
            end
        end else if (step_en) begin
            case (state_q)
                E_SEC:   ss_d = bcd2_step(ss_q, 8'h00, SEC_MAX, step_up);
                E_MIN:   mm_d = bcd2_step(mm_q, 8'h00, MIN_MAX, step_up);
                E_HOUR:  hh_d = bcd2_step(hh_q, 8'h00, HOUR_MAX, step_up);
                E_DAY:   dd_d = bcd2_step(dd_q, DAY_MIN,
                                          days_in_month_bcd(mo_q, yy_q), step_up);
                E_MON:   mo_d = bcd2_step(mo_q, MONTH_MIN, MONTH_MAX, step_up);
                E_YEAR:  yy_d = bcd4_step(yy_q, step_up);
                default: ;
            endcase
        end
        // Valid BCD orders the same as binary, so a plain compare works.
        new_max = days_in_month_bcd(mo_d, yy_d);
        if (dd_d > new_max) dd_d = new_max;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q      <= 8'h00;
            mm_q      <= 8'h00;
            hh_q      <= 8'h00;
            dd_q      <= DAY_MIN;
            mo_q      <= MONTH_MIN;
            yy_q      <= YEAR_RESET;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
        end else begin
            ss_q      <= ss_d;
            mm_q      <= mm_d;
            hh_q      <= hh_d;
            dd_q      <= dd_d;
            mo_q      <= mo_d;
            yy_q      <= yy_d;
            sec_pulse <= sec_pulse_d;
            day_pulse <= day_pulse_d;
        end
    end

`ifdef RTC_WEEKDAY_EN
    logic [2:0] wd_q, wd_d;

    // Advances with each day rollover; date edits leave it untouched.
    always_comb begin
        wd_d = wd_q;
        if (day_pulse_d) begin
            wd_d = (wd_q == WDAY_MAX) ? 3'd0 : wd_q + 3'd1;
        end else if (step_en && (state_q == E_WDAY)) begin
            if (step_up) wd_d = (wd_q == WDAY_MAX) ? 3'd0 : wd_q + 3'd1;
            else         wd_d = (wd_q == 3'd0) ? WDAY_MAX : wd_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_q <= WDAY_RESET;
        else        wd_q <= wd_d;
    end

    assign weekday = wd_q;
`endif

    assign time_bcd   = {hh_q, mm_q, ss_q};
    assign date_bcd   = {dd_q, mo_q, yy_q};
    assign edit_field = state_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// ---------------------------------------------------------------------------
// tb_rtc_calendar_core
// Directed bench for rtc_calendar_core with a short prescaler
// (TICK_DIV=8, FAST_DIV=3). Inputs change on falling edges; outputs are
// sampled on falling edges. Honours RTC_WEEKDAY_EN when defined.
// ---------------------------------------------------------------------------
module tb_rtc_calendar_core;

    localparam int TICK_DIV = 8;
    localparam int FAST_DIV = 3;
`ifdef RTC_WEEKDAY_EN
    localparam int EXIT_FROM_YEAR = 2;
    localparam int EXIT_FROM_HOUR = 5;
`else
    localparam int EXIT_FROM_YEAR = 1;
    localparam int EXIT_FROM_HOUR = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fast;
    logic        edit_next;
    logic        inc;
    logic        dec;
    logic [23:0] time_bcd;
    logic [31:0] date_bcd;
    logic [2:0]  edit_field;
    logic        sec_pulse;
    logic        day_pulse;
`ifdef RTC_WEEKDAY_EN
    logic [2:0]  weekday;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    rtc_calendar_core #(
        .TICK_DIV   (TICK_DIV),
        .FAST_DIV   (FAST_DIV),
        .YEAR_RESET (16'h2024),
        .WDAY_RESET (3'd1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fast       (fast),
        .edit_next  (edit_next),
        .inc        (inc),
        .dec        (dec),
        .time_bcd   (time_bcd),
        .date_bcd   (date_bcd),
        .edit_field (edit_field),
        .sec_pulse  (sec_pulse),
        .day_pulse  (day_pulse)
`ifdef RTC_WEEKDAY_EN
        ,
        .weekday    (weekday)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] date_of(input logic [7:0] d, input logic [7:0] m,
                                            input logic [15:0] y);
        return {d, m, y};
    endfunction

    // ---------------- drivers ----------------
    task automatic press(input logic e, input logic i, input logic d);
        @(negedge clk);
        edit_next = e;
        inc       = i;
        dec       = d;
        @(negedge clk);
        edit_next = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
    endtask

    task automatic press_n(input logic e, input logic i, input logic d, input int n);
        for (int k = 0; k < n; k++) press(e, i, d);
    endtask

    task automatic wait_tick();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sec_pulse) begin
                seen = 1'b1;
                break;
            end
        end
        check("tick_seen", {63'd0, seen}, 64'd1);
    endtask

    // From RUN at 00:00:00: set 23:59:59, return to RUN, take one tick.
    task automatic roll_from_midnight();
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press_n(1, 0, 0, EXIT_FROM_HOUR);
        wait_tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sc;
        int dc;
        rst_n     = 1'b0;
        fast      = 1'b1;
        edit_next = 1'b0;
        inc       = 1'b0;
        dec       = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_time", time_bcd, 24'h000000);
        check("rst_date", date_bcd, date_of(8'h01, 8'h01, 16'h2024));
        check("rst_field", edit_field, 3'd0);
        check("rst_sec_pulse", sec_pulse, 1'b0);
        check("rst_day_pulse", day_pulse, 1'b0);
`ifdef RTC_WEEKDAY_EN
        check("rst_weekday", weekday, 3'd1);
`endif

        // 60 fast ticks = 180 cycles
        rst_n = 1'b1;
        sc = 0;
        dc = 0;
        repeat (180) begin
            @(negedge clk);
            if (sec_pulse) sc++;
            if (day_pulse) dc++;
        end
        check("run60_time", time_bcd, 24'h000100);
        check("run60_sec_pulses", sc, 60);
        check("run60_day_pulses", dc, 0);
        check("run60_date", date_bcd, date_of(8'h01, 8'h01, 16'h2024));
        fast = 1'b0;

        // second field edits
        press(1, 0, 0);
        check("enter_e_sec", edit_field, 3'd1);
        press(0, 0, 1);
        check("sec_dec_wrap", time_bcd, 24'h000159);
        press(0, 1, 1);
        check("inc_dec_ignored", time_bcd, 24'h000159);
        press(1, 1, 0);
        check("next_beats_inc_field", edit_field, 3'd2);
        check("next_beats_inc_time", time_bcd, 24'h000159);

        press_n(0, 0, 1, 2);
        check("min_dec_wrap", time_bcd, 24'h005959);
        press(1, 0, 0);
        press(0, 0, 1);
        check("hour_dec_wrap", time_bcd, 24'h235959);
        press(1, 0, 0);
        press(0, 0, 1);
        check("day_dec_wrap", date_bcd, date_of(8'h31, 8'h01, 16'h2024));
        press(1, 0, 0);
        press(0, 0, 1);
        check("mon_dec_wrap", date_bcd, date_of(8'h31, 8'h12, 16'h2024));
        press(1, 0, 0);
        check("enter_e_year", edit_field, 3'd6);
        press_n(0, 0, 1, 24);
        check("year_dec_2000", date_bcd, date_of(8'h31, 8'h12, 16'h2000));
        press_n(0, 0, 1, 2000);
        check("year_dec_0000", date_bcd, date_of(8'h31, 8'h12, 16'h0000));
        press(0, 0, 1);
        check("year_dec_wrap", date_bcd, date_of(8'h31, 8'h12, 16'h9999));

        // back to RUN with fast prescale: first tick exactly 3 cycles later
        fast = 1'b1;
        press_n(1, 0, 0, EXIT_FROM_YEAR);
        check("back_to_run", edit_field, 3'd0);
        @(negedge clk);
        check("tick_not_early1", sec_pulse, 1'b0);
        @(negedge clk);
        check("tick_not_early2", sec_pulse, 1'b0);
        @(negedge clk);
        fast = 1'b0;
        check("y9999_sec_pulse", sec_pulse, 1'b1);
        check("y9999_day_pulse", day_pulse, 1'b1);
        check("y9999_time", time_bcd, 24'h000000);
        check("y9999_date", date_bcd, date_of(8'h01, 8'h01, 16'h0000));
`ifdef RTC_WEEKDAY_EN
        check("y9999_weekday", weekday, 3'd2);
`endif
        @(negedge clk);
        check("day_pulse_one_cycle", day_pulse, 1'b0);
        check("sec_pulse_one_cycle", sec_pulse, 1'b0);

        // 28-02-2100 23:59:59 -> 01-03-2100 (century, not leap)
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 1, 0);
        check("mon_inc_clamp_leap0000", date_bcd, date_of(8'h29, 8'h02, 16'h0000));
        press(1, 0, 0);
        press(0, 1, 0);
        check("year_inc_clamp", date_bcd, date_of(8'h28, 8'h02, 16'h0001));
        press_n(0, 1, 0, 2099);
        check("year_inc_2100", date_bcd, date_of(8'h28, 8'h02, 16'h2100));
        press_n(1, 0, 0, EXIT_FROM_YEAR);
        wait_tick();
        check("y2100_time", time_bcd, 24'h000000);
        check("y2100_date", date_bcd, date_of(8'h01, 8'h03, 16'h2100));
        check("y2100_day_pulse", day_pulse, 1'b1);

        // 28-02-2000 23:59:59 -> 29-02-2000 (divisible by 400)
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        check("day_dec_wrap_mar", date_bcd, date_of(8'h31, 8'h03, 16'h2100));
        press(1, 0, 0);
        press(0, 0, 1);
        check("mon_dec_clamp_2100", date_bcd, date_of(8'h28, 8'h02, 16'h2100));
        press(1, 0, 0);
        press_n(0, 0, 1, 100);
        check("year_dec_2000b", date_bcd, date_of(8'h28, 8'h02, 16'h2000));
        press_n(1, 0, 0, EXIT_FROM_YEAR);
        wait_tick();
        check("y2000_time", time_bcd, 24'h000000);
        check("y2000_date", date_bcd, date_of(8'h29, 8'h02, 16'h2000));

        // 28-02-2024 23:59:59 -> 29-02-2024
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        press(1, 0, 0);
        press_n(0, 1, 0, 24);
        check("year_inc_2024", date_bcd, date_of(8'h28, 8'h02, 16'h2024));
        press_n(1, 0, 0, EXIT_FROM_YEAR);
        wait_tick();
        check("y2024_date", date_bcd, date_of(8'h29, 8'h02, 16'h2024));

        // day inc wraps 29 -> 01 in Feb 2024
        press_n(1, 0, 0, 4);
        check("enter_e_day", edit_field, 3'd4);
        press(0, 1, 0);
        check("day_inc_wrap_feb", date_bcd, date_of(8'h01, 8'h02, 16'h2024));
        press(1, 0, 0);
        press(0, 1, 0);
        check("mon_inc", date_bcd, date_of(8'h01, 8'h03, 16'h2024));
        press(1, 0, 0);
        press(0, 0, 1);
        check("year_dec_2023", date_bcd, date_of(8'h01, 8'h03, 16'h2023));
        press_n(1, 0, 0, EXIT_FROM_YEAR);

        // 31-03-2023, month dec -> 28-02-2023
        press_n(1, 0, 0, 4);
        press(0, 0, 1);
        check("day_dec_31_03", date_bcd, date_of(8'h31, 8'h03, 16'h2023));
        press(1, 0, 0);
        press(0, 0, 1);
        check("mon_dec_clamp_2023", date_bcd, date_of(8'h28, 8'h02, 16'h2023));
        check("time_held_in_edit", time_bcd, 24'h000000);

`ifdef RTC_WEEKDAY_EN
        check("weekday_after_4_rolls", weekday, 3'd5);
        press(1, 0, 0);
        press(1, 0, 0);
        check("enter_e_wday", edit_field, 3'd7);
        press(0, 1, 0);
        check("wday_inc", weekday, 3'd6);
        press(0, 1, 0);
        check("wday_inc_wrap", weekday, 3'd0);
        press(0, 0, 1);
        check("wday_dec_wrap", weekday, 3'd6);
        press(1, 0, 0);
        check("wday_to_run", edit_field, 3'd0);
        for (int k = 1; k <= 7; k++) begin
            roll_from_midnight();
            check("wday_roll", weekday, 3'((6 + k) % 7));
        end
`endif

        // asynchronous reset away from a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_time", time_bcd, 24'h000000);
        check("async_rst_date", date_bcd, date_of(8'h01, 8'h01, 16'h2024));
        check("async_rst_field", edit_field, 3'd0);
`ifdef RTC_WEEKDAY_EN
        check("async_rst_weekday", weekday, 3'd1);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rtc_calendar_core.md
# rtc_calendar_core

Parametrised BCD real-time clock and calendar core: HH:MM:SS plus DD-MM-YYYY with full Gregorian leap rule, a selectable tick rate, and an in-place edit state machine driven by pre-debounced button pulses. It sits between the board clock and the 7-segment display mux, which consumes its packed BCD outputs. It supersedes the fixed-rate counter, adding date editing, day clamping, century leap handling and status pulses.

## Interface
- TICK_DIV, 50_000_000, clk cycles per second tick in normal mode (≥2)
- FAST_DIV, 500, clk cycles per tick when `fast`=1 (≥2, ≤TICK_DIV)
- YEAR_RESET, 16'h2024, BCD year loaded at reset
- WDAY_RESET, 3'd1, weekday loaded at reset (0=Sun..6=Sat; used only with RTC_WEEKDAY_EN)
- clk  in  1  core clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- fast  in  1  select FAST_DIV prescale
- edit_next  in  1  single-cycle pulse, advance edit field
- inc  in  1  single-cycle pulse, increment selected field
- dec  in  1  single-cycle pulse, decrement selected field
- time_bcd  out  24  {hh, mm, ss}, 2 BCD digits each
- date_bcd  out  32  {dd, mo, yyyy}, BCD
- edit_field  out  3  current FSM state encoding (drives LEDs)
- sec_pulse  out  1  one-cycle pulse when seconds advance in RUN
- day_pulse  out  1  one-cycle pulse on 23:59:59→00:00:00 rollover
- weekday  out  3  0..6 (present only with RTC_WEEKDAY_EN)

## Operation
- FSM states/encodings: RUN=0, E_SEC=1, E_MIN=2, E_HOUR=3, E_DAY=4, E_MON=5, E_YEAR=6. edit_next moves to next state; E_YEAR→RUN (E_YEAR→E_WDAY=7→RUN with macro).
- RUN: prescaler counts 0..DIV-1, DIV = fast ? FAST_DIV : TICK_DIV; on count ≥ DIV-1 count clears and a tick fires. Tick advances ss with full cascade: ss 59→00 carries mm, mm 59→00 carries hh, hh 23→00 carries day; day at month max→01 carries month; month 12→01 carries year; year 9999→0000.
- Days in month: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb 29 if leap else 28. Leap: yyyy%4==0 and (yyyy%100!=0 or yyyy%400==0), evaluated on BCD digits without binary conversion.
- Edit states: prescaler held at 0, no ticks, sec_pulse/day_pulse held 0. inc/dec wrap the selected field within its range only, no carry: ss/mm 00..59, hh 00..23, dd 01..max, mo 01..12, yyyy 0000..9999.
- Day clamp: any month or year change (edit or cascade) whose new max < dd sets dd := new max in the same update.
- On return to RUN, prescaler starts from 0; first tick is DIV cycles later.
- Priority: edit_next > inc/dec; inc and dec together → both ignored; inc/dec in RUN ignored.

## Timing
- All outputs registered. Reset values: time_bcd 24'h000000, date_bcd {8'h01, 8'h01, YEAR_RESET}, edit_field 0, sec_pulse 0, day_pulse 0, weekday WDAY_RESET.
- Tick: time/date registers and sec_pulse update on the edge where count = DIV-1; pulses high exactly one cycle.
- inc/dec/edit_next: effect visible on outputs the cycle after the pulse edge.
- fast toggled mid-count: count ≥ new DIV-1 fires a tick on the next edge, then normal period.
- rst_n asserted mid-operation: everything returns to reset values asynchronously, FSM to RUN.

## Configuration
- RTC_WEEKDAY_EN defined: weekday register and port exist; incremented mod 7 on each day_pulse; extra edit state E_WDAY (inc/dec wrap 0..6). Date edits do not recompute weekday.
- Undefined: no weekday port/logic; E_YEAR→RUN.

## Structure
- Package rtc_pkg: edit-state enum, bcd2_t/bcd4_t typedefs, MONTH/field limit constants, functions is_leap_bcd() and days_in_month_bcd().
- Sub-module rtc_prescaler: parametrised counter with hold/clear input, runtime divisor select, tick output.

## Test plan
- Reset, fast=1, run 60 ticks → time_bcd 24'h000100, 60 sec_pulse, no day_pulse.
- Edit to 23:59:59, 31-12-9999, RUN, one tick → 24'h000000, date {01,01,0000}, day_pulse=1 one cycle.
- Year 2100, 28-02 23:59:59 tick → 01-03; year 2000 same → 29-02; 2024 → 29-02.
- Set 31-03-2023, E_MON dec → 28-02 (clamp); set year 2024, mon 02, day inc from 29 → 01.
- In E_SEC at ss=00: dec → 59, mm unchanged; inc+dec same cycle → no change; edit_next+inc same cycle → field advances only.
- RTC_WEEKDAY_EN: reset weekday=1, one day rollover → 2; seven rollovers from 6 → 6 with wrap via 0.
